dac_serializer: RTL and testbench
=================================

Name: dac_serializer

Overview:
- Downstream stage of the NCO: takes each P-bit amplitude sample and ships it to an external serial DAC (MCP4921-class, 16-bit frame) over a write-only SPI link.
- Generates the LDAC update pulse to the DAC.
- Holds one pending sample so that the NCO never stalls; the newest sample always wins.
- Sits between nco.amplitude and the board DAC pins.

Parameters:
- P, 12, amplitude/DAC data width
- HB, 4, header bit count prepended to each frame
- HEADER, 4'b0011, header bits sent MSB first (A/B=0, BUF=0, GA=1, SHDN=1)
- DIV, 4, clk cycles per sclk half-period (>=1)
- OFFSET_BIN, 1, if 1 invert sample MSB (two's complement -> offset binary)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  accept new samples when high
- sample_valid  in  1  one-cycle strobe, amplitude valid
- amplitude  in  P  sample from NCO
- clr_overrun  in  1  clears overrun flag
- dac_sclk  out  1  SPI clock, idle low
- dac_mosi  out  1  serial data, MSB first
- dac_cs_n  out  1  frame select, active low
- dac_ldac_n  out  1  DAC latch pulse, active low
- busy  out  1  high whenever state != IDLE
- overrun  out  1  sticky: a pending sample was overwritten

Behaviour:
- Frame width: W = HB + P (16 by default). Shift word: {HEADER, amplitude with MSB optionally inverted}. The inversion is applied at capture.
- All outputs are registered. Reset values: dac_sclk=0, dac_mosi=0, dac_cs_n=1, dac_ldac_n=1, busy=0, overrun=0. Reset also clears state, pending, and the counters.
- Reset asserted mid-frame aborts the frame immediately: the reset values appear on the next edge, and no LDAC pulse is issued.
- Capture:
  - On a clk edge with sample_valid=1 and en=1, amplitude goes into the pending register and pend_valid is set.
  - With en=0, the strobe is ignored. A frame already in flight still completes.
- Overrun:
  - Capture while pend_valid=1, and pending is not being consumed that same cycle, overwrites pending and sets overrun.
  - clr_overrun clears overrun. If clr_overrun and a new overrun occur in the same cycle, set wins.
- FSM states: IDLE, SETUP, SHIFT, GAP, LDAC.
- IDLE:
  - When pend_valid=1: load the shift register, clear pend_valid, and go to SETUP.
  - A capture in the same cycle as this consume re-sets pend_valid with the new sample, and is not an overrun.
- SETUP:
  - dac_cs_n=0, dac_mosi = word MSB, dac_sclk=0.
  - Lasts DIV cycles, then SHIFT.
- SHIFT:
  - dac_sclk toggles every DIV cycles, giving W rising edges.
  - dac_mosi changes only on falling edges and is stable a full half-period around each rising edge (DAC samples on rising).
  - After the W-th falling edge (sclk back to 0), go to GAP.
- GAP: dac_cs_n=1, dac_mosi=0, lasts DIV cycles, then LDAC.
- LDAC: dac_ldac_n=0 for DIV cycles, then IDLE.
- Frame duration, from the first cycle of SETUP to the return to IDLE, is exactly DIV*(2W+3) clk cycles: 140 with defaults.
- Latency: a capture into an empty pending register while IDLE gives dac_cs_n low 2 clk edges after the strobe edge.
- Maximum sustained sample rate without overrun is one sample per DIV*(2W+3)+1 cycles.
- Counters:
  - Half-period counter: ceil(log2(DIV)) bits, wraps at DIV-1.
  - Bit counter: ceil(log2(W+1)) bits, counts rising edges 0..W. No other wrap-around.

Decomposition:
- Shared package (dds_pkg): FSM state encoding constants (IDLE, SETUP, SHIFT, GAP, LDAC) and the default HEADER/DIV constants.
- One natural sub-module: dac_sclk_gen, the DIV half-period tick generator with enable/clear.
  - It emits a one-cycle tick at each half-period boundary.
  - The FSM consumes the ticks for all state timing.

Test Plan:
- Reset, then idle 50 cycles -> cs_n=1, ldac_n=1, sclk=0, busy=0, overrun=0 throughout.
- Single sample 12'h800, OFFSET_BIN=1 -> captured on 16 rising sclk edges as 16'h3000; cs_n low exactly 4+128 cycles; ldac_n low 4 cycles; busy high 140 cycles.
- Sample 12'h7FF, then 12'h123 strobed 10 cycles later (mid-frame) -> first frame 16'h3FFF, second 16'h3923, cs_n high for at least GAP+LDAC between frames, overrun=0.
- Strobes of 12'h111, 12'h222, 12'h333 during one frame -> next frame carries 12'h333 (16'h3B33), overrun=1; after clr_overrun pulse, overrun=0.
- reset pulsed at the 5th rising sclk edge of a frame -> next edge cs_n=1, sclk=0, ldac_n stays 1, pending cleared, no further frame.
- en=0 with a strobe of 12'hABC -> no frame started; en=0 asserted during a frame -> current frame completes, and a strobe arriving then is dropped.

Source files
------------

// File: rtl/dac_serializer_pkg.sv
// Shared definitions for the DAC serializer: FSM state encoding and default
// frame header / clock divider values.
package dac_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_LDAC  = 3'd4
  } state_t;

  localparam logic [3:0] DEF_HEADER = 4'b0011;
  localparam int         DEF_DIV    = 4;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dac_serializer_if.sv
// Sample-side and DAC-pin bundle of the serializer. The master drives the NCO
// side; the slave is the serializer that drives the board DAC pins.
interface dac_serializer_if #(
  parameter int P = 12
);
  logic         en;
  logic         sample_valid;
  logic [P-1:0] amplitude;
  logic         clr_overrun;
  logic         dac_sclk;
  logic         dac_mosi;
  logic         dac_cs_n;
  logic         dac_ldac_n;
  logic         busy;
  logic         overrun;

  modport master (
    output en, sample_valid, amplitude, clr_overrun,
    input  dac_sclk, dac_mosi, dac_cs_n, dac_ldac_n, busy, overrun
  );

  modport slave (
    input  en, sample_valid, amplitude, clr_overrun,
    output dac_sclk, dac_mosi, dac_cs_n, dac_ldac_n, busy, overrun
  );
endinterface

// File: rtl/dac_serializer_sclk_gen.sv
// Half-period tick generator: one-cycle o_tick every DIV enabled cycles,
// restarted by i_clr or whenever the enable drops.
module dac_sclk_gen
  import dac_serializer_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);
  localparam int             CW   = cnt_width(DIV);
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/dac_serializer.sv
// Serializes NCO amplitude samples into 16-bit SPI frames for an MCP4921-class
// DAC, followed by an LDAC latch pulse. One pending slot, newest sample wins.
module dac_serializer
  import dac_serializer_pkg::*;
#(
  parameter int              P          = 12,
  parameter int              HB         = 4,
  parameter logic [HB-1:0]   HEADER     = DEF_HEADER,
  parameter int              DIV        = DEF_DIV,
  parameter int              OFFSET_BIN = 1
) (
  input  logic             clk,
  input  logic             reset,
  dac_serializer_if.slave  bus
);
  localparam int           W        = HB + P;
  localparam int           BW       = $clog2(W + 1);
  localparam logic [P-1:0] MSB_FLIP = (OFFSET_BIN != 0) ? (P'(1) << (P - 1)) : '0;

  state_t          r_state;
  logic [P-1:0]    r_pend;
  logic            r_pend_valid;
  logic [W-1:0]    r_shift;
  logic            r_sclk_int;
  logic [BW-1:0]   r_bit_cnt;
  logic            r_sclk, r_mosi, r_cs_n, r_ldac_n, r_busy, r_overrun;

  logic            w_capture, w_consume, w_ovr_set, w_tick;
  logic [P-1:0]    w_sample;

  assign w_capture = bus.sample_valid && bus.en;
  assign w_consume = (r_state == ST_IDLE) && r_pend_valid;
  assign w_ovr_set = w_capture && r_pend_valid && !w_consume;
  assign w_sample  = bus.amplitude ^ MSB_FLIP;

  dac_sclk_gen #(.DIV(DIV)) u_sclk_gen (
    .clk    (clk),
    .reset  (reset),
    .i_en   (r_state != ST_IDLE),
    .i_clr  (w_consume),
    .o_tick (w_tick)
  );

  // Pins are registered from the previous cycle's state, so every pin lags the
  // internal FSM by exactly one clock and stays mutually aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_shift      <= '0;
      r_sclk_int   <= 1'b0;
      r_bit_cnt    <= '0;
      r_sclk       <= 1'b0;
      r_mosi       <= 1'b0;
      r_cs_n       <= 1'b1;
      r_ldac_n     <= 1'b1;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_pend       <= w_sample;
        r_pend_valid <= 1'b1;
      end else if (w_consume) begin
        r_pend_valid <= 1'b0;
      end

      if (w_ovr_set)            r_overrun <= 1'b1;
      else if (bus.clr_overrun) r_overrun <= 1'b0;

      r_cs_n   <= !((r_state == ST_SETUP) || (r_state == ST_SHIFT));
      r_mosi   <= ((r_state == ST_SETUP) || (r_state == ST_SHIFT)) ? r_shift[W-1] : 1'b0;
      r_sclk   <= (r_state == ST_SHIFT) ? r_sclk_int : 1'b0;
      r_ldac_n <= (r_state != ST_LDAC);
      r_busy   <= (r_state != ST_IDLE);

      case (r_state)
        ST_IDLE: begin
          if (w_consume) begin
            r_shift    <= {HEADER, r_pend};
            r_bit_cnt  <= '0;
            r_sclk_int <= 1'b0;
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: if (w_tick) r_state <= ST_SHIFT;
        ST_SHIFT: begin
          if (w_tick) begin
            if (!r_sclk_int) begin
              r_sclk_int <= 1'b1;
              r_bit_cnt  <= r_bit_cnt + BW'(1);
            end else begin
              // Data advances on the falling edge; DAC samples on the rising one.
              r_sclk_int <= 1'b0;
              r_shift    <= {r_shift[W-2:0], 1'b0};
              if (r_bit_cnt == BW'(W)) r_state <= ST_GAP;
            end
          end
        end
        ST_GAP:  if (w_tick) r_state <= ST_LDAC;
        ST_LDAC: if (w_tick) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dac_sclk   = r_sclk;
  assign bus.dac_mosi   = r_mosi;
  assign bus.dac_cs_n   = r_cs_n;
  assign bus.dac_ldac_n = r_ldac_n;
  assign bus.busy       = r_busy;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_dac_serializer.sv
// Bench for dac_serializer: slot/frame-time reference model feeds an expected
// frame queue; a pin monitor decodes SPI frames and compares against it.
module tb_dac_serializer;
  import dac_serializer_pkg::*;

  localparam int         P     = 12;
  localparam int         HB    = 4;
  localparam int         DIV   = 4;
  localparam int         W     = HB + P;
  localparam int         FRAME = DIV * (2 * W + 3);
  localparam logic [3:0] HDR   = 4'b0011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dac_serializer_if #(.P(P)) bus ();

  dac_serializer #(
    .P(P), .HB(HB), .HEADER(HDR), .DIV(DIV), .OFFSET_BIN(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending slot plus a frame occupying FRAME cycles.
  logic [15:0] exp_q[$];
  int          m_busy     = 0;
  bit          m_busy_out = 1'b0;
  bit          m_pend     = 1'b0;
  logic [11:0] m_val      = '0;
  bit          m_ovr      = 1'b0;
  int          m_aborts   = 0;

  always @(posedge clk) begin
    bit consume;
    bit ovr_set;
    if (reset) begin
      if (m_busy > 2 * DIV) m_aborts++;
      m_busy     = 0;
      m_busy_out = 1'b0;
      m_pend     = 1'b0;
      m_ovr      = 1'b0;
    end else begin
      m_busy_out = (m_busy != 0);
      consume    = (m_busy == 0) && m_pend;
      ovr_set    = 1'b0;
      if (consume) begin
        exp_q.push_back({HDR, m_val});
        m_busy = FRAME;
        m_pend = 1'b0;
      end else if (m_busy > 0) begin
        m_busy--;
      end
      if (bus.en && bus.sample_valid) begin
        ovr_set = m_pend;
        m_pend  = 1'b1;
        m_val   = bus.amplitude ^ 12'h800;
      end
      if (ovr_set)              m_ovr = 1'b1;
      else if (bus.clr_overrun) m_ovr = 1'b0;
    end
  end

  // Pin monitor, sampled on the falling clock edge.
  bit          prev_cs = 1'b1, prev_sclk = 1'b0, prev_ldac = 1'b1, prev_mosi = 1'b0;
  bit          mosi_rise = 1'b0, frame_ok = 1'b0, seen_frame = 1'b0;
  int          bits = 0, cs_low = 0, since_cs_rise = 0, ldac_low = 0, mon_aborts = 0;
  logic [15:0] word = '0;

  always @(negedge clk) begin
    logic [15:0] exp_word;
    check("busy", 32'(bus.busy), 32'(m_busy_out));
    check("overrun", 32'(bus.overrun), 32'(m_ovr));
    if (!m_busy_out)
      check("idle_pins", 32'({bus.dac_cs_n, bus.dac_ldac_n, bus.dac_sclk, bus.dac_mosi}), 32'h0000000C);

    if (prev_cs && !bus.dac_cs_n) begin
      if (seen_frame) check("cs_gap", 32'(since_cs_rise >= 2 * DIV), 32'd1);
      bits = 0; word = '0; cs_low = 0;
    end
    if (!bus.dac_cs_n) cs_low++;

    if (!prev_sclk && bus.dac_sclk) begin
      word      = {word[14:0], bus.dac_mosi};
      bits++;
      mosi_rise = bus.dac_mosi;
      check("mosi_setup", 32'(bus.dac_mosi), 32'(prev_mosi));
    end
    if (prev_sclk && bus.dac_sclk) check("mosi_hold", 32'(bus.dac_mosi), 32'(mosi_rise));

    if (!prev_cs && bus.dac_cs_n) begin
      since_cs_rise = 0;
      seen_frame    = 1'b1;
      if (bits != W && mon_aborts < m_aborts) begin
        mon_aborts++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        frame_ok = 1'b0;
      end else begin
        check("frame_bits", 32'(bits), 32'(W));
        check("cs_low_len", 32'(cs_low), 32'(DIV * (2 * W + 1)));
        check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_word = exp_q.pop_front();
          check("frame_word", 32'(word), 32'(exp_word));
        end
        frame_ok = 1'b1;
      end
    end else begin
      since_cs_rise++;
    end

    if (prev_ldac && !bus.dac_ldac_n) begin
      check("ldac_gap", 32'(since_cs_rise), 32'(DIV));
      check("ldac_after_frame", 32'(frame_ok), 32'd1);
      frame_ok = 1'b0;
      ldac_low = 0;
    end
    if (!bus.dac_ldac_n) ldac_low++;
    if (!prev_ldac && bus.dac_ldac_n) check("ldac_width", 32'(ldac_low), 32'(DIV));

    prev_cs   = bus.dac_cs_n;
    prev_sclk = bus.dac_sclk;
    prev_ldac = bus.dac_ldac_n;
    prev_mosi = bus.dac_mosi;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [11:0] a);
    bus.sample_valid = 1'b1;
    bus.amplitude    = a;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    bus.clr_overrun  = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while ((m_busy != 0 || m_pend || bus.busy) && k < limit) begin
      cyc(1);
      k++;
    end
    check("idle_timeout", 32'(k < limit), 32'd1);
    cyc(3);
  endtask

  task automatic count_cs_low(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (!bus.dac_cs_n || !bus.dac_ldac_n) lows++;
    end
  endtask

  initial begin
    int cnt;
    bit ps;
    bus.en = 1'b0; bus.sample_valid = 1'b0; bus.amplitude = '0; bus.clr_overrun = 1'b0;

    // Reset and idle
    cyc(3);
    reset = 1'b0;
    check("rst_pins", 32'({bus.dac_cs_n, bus.dac_ldac_n, bus.dac_sclk, bus.dac_mosi, bus.busy, bus.overrun}), 32'h30);
    cyc(50);

    // Single sample, latency and busy length
    bus.en = 1'b1;
    strobe(12'h800);
    check("lat_e0", 32'(bus.dac_cs_n), 32'd1);
    cyc(1);
    check("lat_e1", 32'(bus.dac_cs_n), 32'd1);
    cyc(1);
    check("lat_e2", 32'(bus.dac_cs_n), 32'd0);
    cnt = 32'(bus.busy);
    for (int i = 0; i < 300; i++) begin
      cyc(1);
      if (bus.busy) cnt++;
    end
    check("busy_len", 32'(cnt), 32'(FRAME));

    // Mid-frame strobe queues next frame without overrun
    strobe(12'h7FF);
    cyc(9);
    strobe(12'h123);
    wait_idle(600);
    check("no_overrun", 32'(bus.overrun), 32'd0);

    // Three strobes during one frame: newest wins, overrun sticky until cleared
    strobe(12'h456);
    cyc(20);
    strobe(12'h111);
    cyc(5);
    strobe(12'h222);
    cyc(5);
    strobe(12'h333);
    wait_idle(600);
    check("overrun_set", 32'(bus.overrun), 32'd1);
    bus.clr_overrun = 1'b1;
    cyc(1);
    bus.clr_overrun = 1'b0;
    check("overrun_clr", 32'(bus.overrun), 32'd0);

    // Reset at the 5th rising sclk edge aborts the frame and drops pending
    strobe(12'h5A5);
    cyc(10);
    strobe(12'h0F0);
    cnt = 0;
    ps  = bus.dac_sclk;
    for (int i = 0; i < 200 && cnt < 5; i++) begin
      cyc(1);
      if (!ps && bus.dac_sclk) cnt++;
      ps = bus.dac_sclk;
    end
    check("sclk5_seen", 32'(cnt), 32'd5);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("abort_pins", 32'({bus.dac_cs_n, bus.dac_ldac_n, bus.dac_sclk, bus.busy}), 32'hC);
    count_cs_low(300, cnt);
    check("abort_no_frame", 32'(cnt), 32'd0);

    // en=0: idle strobe ignored; en drop mid-frame drops strobe, frame completes
    bus.en = 1'b0;
    strobe(12'hABC);
    count_cs_low(50, cnt);
    check("en0_no_frame", 32'(cnt), 32'd0);
    bus.en = 1'b1;
    strobe(12'h321);
    cyc(20);
    bus.en = 1'b0;
    strobe(12'h654);
    wait_idle(600);
    count_cs_low(50, cnt);
    check("en0_dropped", 32'(cnt), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      bus.en          = ($urandom_range(0, 7) != 0);
      bus.clr_overrun = ($urandom_range(0, 9) == 0);
      strobe(12'($urandom));
      cyc($urandom_range(0, 180));
    end
    bus.en = 1'b1;
    wait_idle(1000);
    cyc(10);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
